my_interface: RTL and testbench

//   Signal-bundle endpoint for the a/b/c handshake group.
//   - Takes two single-bit inputs a and b.
//   - Produces c = a & b, both combinationally and as a registered copy.
//   - Also provides per-signal rising-edge pulses and a saturating count of rising edges on c.
//   - Sits between stimulus sources and any consumer of the a/b/c group, so that

---
 rtl/my_interface.sv | 65 ++++++
 tb/tb_my_interface.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/my_interface.sv
// Endpoint for the a/b/c signal group: combinational and registered c = a & b,
// one-cycle rising-edge pulses for a, b and c, and a saturating count of c rises.
module my_interface #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_i,
    input  logic             b_i,
    input  logic             clr_i,
    output logic             c_o,
    output logic             c_q_o,
    output logic             a_rise_o,
    output logic             b_rise_o,
    output logic             c_rise_o,
    output logic [CNT_W-1:0] c_cnt_o,
    output logic             cnt_sat_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic a_d;
    logic b_d;
    logic c_d;
    logic c_now;
    logic c_rise_now;

    assign c_now      = a_i & b_i;
    assign c_rise_now = c_now & ~c_d;

    // Combinational path is deliberately independent of reset.
    assign c_o = c_now;

    // NOTE: non-blocking assignments so every flop samples the pre-edge value of
    // its neighbours; blocking here would let c_d feed the rise logic same-edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_d      <= 1'b0;
            b_d      <= 1'b0;
            c_d      <= 1'b0;
            c_q_o    <= 1'b0;
            a_rise_o <= 1'b0;
            b_rise_o <= 1'b0;
            c_rise_o <= 1'b0;
            c_cnt_o  <= '0;
        end else begin
            a_d      <= a_i;
            b_d      <= b_i;
            c_d      <= c_now;
            c_q_o    <= c_now;
            a_rise_o <= a_i & ~a_d;
            b_rise_o <= b_i & ~b_d;
            c_rise_o <= c_rise_now;
            // Clear beats a coincident increment; the count sticks at all-ones.
            if (clr_i) begin
                c_cnt_o <= '0;
            end else if (c_rise_now && (c_cnt_o != CNT_MAX)) begin
                c_cnt_o <= c_cnt_o + 1'b1;
            end
        end
    end

    assign cnt_sat_o = (c_cnt_o == CNT_MAX);

endmodule

// File: tb/tb_my_interface.sv
// Self-checking bench for my_interface: a per-cycle reference model of the
// a/b/c group plus directed scenarios with hand-computed literal expectations.
module tb_my_interface;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             a_i;
    logic             b_i;
    logic             clr_i;
    logic             c_o;
    logic             c_q_o;
    logic             a_rise_o;
    logic             b_rise_o;
    logic             c_rise_o;
    logic [CNT_W-1:0] c_cnt_o;
    logic             cnt_sat_o;

    int n_checks = 0;
    int n_errors = 0;
    logic run_cmp = 1'b0;

    my_interface #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_i       (a_i),
        .b_i       (b_i),
        .clr_i     (clr_i),
        .c_o       (c_o),
        .c_q_o     (c_q_o),
        .a_rise_o  (a_rise_o),
        .b_rise_o  (b_rise_o),
        .c_rise_o  (c_rise_o),
        .c_cnt_o   (c_cnt_o),
        .cnt_sat_o (cnt_sat_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what was sampled at the previous edge (0 after reset),
    // and an unbounded count of c rises since the last clear/reset.
    logic prev_a, prev_b, prev_c;
    logic exp_cq, exp_ar, exp_br, exp_cr;
    int   rises_since_clr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_a          <= 1'b0;
            prev_b          <= 1'b0;
            prev_c          <= 1'b0;
            exp_cq          <= 1'b0;
            exp_ar          <= 1'b0;
            exp_br          <= 1'b0;
            exp_cr          <= 1'b0;
            rises_since_clr <= 0;
        end else begin
            prev_a <= a_i;
            prev_b <= b_i;
            prev_c <= a_i && b_i;
            exp_cq <= a_i && b_i;
            exp_ar <= a_i && !prev_a;
            exp_br <= b_i && !prev_b;
            exp_cr <= (a_i && b_i) && !prev_c;
            if (clr_i)
                rises_since_clr <= 0;
            else if ((a_i && b_i) && !prev_c)
                rises_since_clr <= rises_since_clr + 1;
        end
    end

    function automatic int model_cnt();
        return (rises_since_clr > CNT_MAX) ? CNT_MAX : rises_since_clr;
    endfunction

    always @(negedge clk) begin
        if (run_cmp) begin
            check("cmp_c",      int'(c_o),       int'(a_i & b_i));
            check("cmp_c_q",    int'(c_q_o),     int'(exp_cq));
            check("cmp_a_rise", int'(a_rise_o),  int'(exp_ar));
            check("cmp_b_rise", int'(b_rise_o),  int'(exp_br));
            check("cmp_c_rise", int'(c_rise_o),  int'(exp_cr));
            check("cmp_cnt",    int'(c_cnt_o),   model_cnt());
            check("cmp_sat",    int'(cnt_sat_o), int'(model_cnt() == CNT_MAX));
        end
    end

    // Drive inputs 2 time units after an edge, then advance to just past the next edge.
    task automatic cyc(input logic a, input logic b, input logic clr);
        a_i   = a;
        b_i   = b;
        clr_i = clr;
        @(posedge clk);
        #2;
    endtask

    logic [1:0] tt_ab;
    logic [3:0] tt_c = 4'b1000;
    int na, nb, nc;

    initial begin
        rst_n = 1'b0;
        a_i   = 1'b0;
        b_i   = 1'b0;
        clr_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        run_cmp = 1'b1;
        check("rst_c_q", int'(c_q_o), 0);
        check("rst_cnt", int'(c_cnt_o), 0);
        rst_n = 1'b1;

        // Truth table: c_o immediate, c_q_o one edge later.
        for (int i = 0; i < 4; i++) begin
            tt_ab = 2'(i);
            a_i   = tt_ab[1];
            b_i   = tt_ab[0];
            #1;
            check("tt_c", int'(c_o), int'(tt_c[i]));
            @(posedge clk);
            #2;
            check("tt_c_q", int'(c_q_o), int'(tt_c[i]));
        end
        cyc(1'b0, 1'b0, 1'b1);
        check("tt_clr_cnt", int'(c_cnt_o), 0);

        // Edge pulses: a, then b two cycles later, both held for 5 cycles.
        na = 0; nb = 0; nc = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, (i >= 2), 1'b0);
            na += int'(a_rise_o);
            nb += int'(b_rise_o);
            nc += int'(c_rise_o);
        end
        check("edge_na", na, 1);
        check("edge_nb", nb, 1);
        check("edge_nc", nc, 1);
        check("edge_cnt", int'(c_cnt_o), 1);
        cyc(1'b0, 1'b0, 1'b0);

        // Clear priority with the count at 7.
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b1, 1'b1, 1'b0);
        end
        check("clr_pre_cnt", int'(c_cnt_o), 7);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        check("clr_cnt", int'(c_cnt_o), 0);
        check("clr_c_rise", int'(c_rise_o), 1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        check("clr_next_cnt", int'(c_cnt_o), 1);

        // Saturation: 20 c rises with a held high.
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            if (i == 13) begin
                check("sat_14_cnt", int'(c_cnt_o), 14);
                check("sat_14_flag", int'(cnt_sat_o), 0);
            end
            cyc(1'b1, 1'b0, 1'b0);
        end
        check("sat_cnt", int'(c_cnt_o), 15);
        check("sat_flag", int'(cnt_sat_o), 1);
        cyc(1'b1, 1'b1, 1'b0);
        check("sat_hold", int'(c_cnt_o), 15);

        // Mid-cycle reset with a = b = 1 and the count at 3.
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            if (i < 2) cyc(1'b1, 1'b0, 1'b0);
        end
        check("mr_pre_cnt", int'(c_cnt_o), 3);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_c", int'(c_o), 1);
        check("mr_c_q", int'(c_q_o), 0);
        check("mr_rises", int'({a_rise_o, b_rise_o, c_rise_o}), 0);
        check("mr_cnt", int'(c_cnt_o), 0);
        check("mr_sat", int'(cnt_sat_o), 0);
        @(posedge clk);
        #2;
        check("mr_hold_c_q", int'(c_q_o), 0);

        // Release with a = b = 1 already high: every history flop reads 0.
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("pr_rises", int'({a_rise_o, b_rise_o, c_rise_o}), 7);
        check("pr_cnt", int'(c_cnt_o), 1);
        cyc(1'b1, 1'b1, 1'b0);
        check("pr_no_repeat", int'({a_rise_o, b_rise_o, c_rise_o}), 0);
        check("pr_cnt_hold", int'(c_cnt_o), 1);
        cyc(1'b0, 1'b0, 1'b0);

        @(negedge clk);
        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
